// File: rtl/hamming_pkg.sv
// Shared types and constants for the serial Hamming(7,4) receiver.
package hamming_pkg;

    localparam int POS_W  = 3;
    localparam int CW_LEN = 7;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // Bit i of the codeword carries position i+1; the syndrome names the failing position.
    function automatic logic [2:0] syndrome_of(input logic [CW_LEN-1:0] code);
        logic s1;
        logic s2;
        logic s4;
        s1 = code[0] ^ code[2] ^ code[4] ^ code[6];
        s2 = code[1] ^ code[2] ^ code[5] ^ code[6];
        s4 = code[3] ^ code[4] ^ code[5] ^ code[6];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming_syndrome_correct.sv
// Combinational single-error correction of one 7-bit Hamming codeword.
module hamming_syndrome_correct
    import hamming_pkg::*;
(
    input  logic [CW_LEN-1:0] code,
    output logic [3:0]        data,
    output logic              err
);

    logic [2:0]        syn;
    logic [2:0]        flip_idx;
    logic [CW_LEN-1:0] fixed;

    always_comb begin
        syn      = syndrome_of(code);
        flip_idx = syn - 3'd1;
        fixed    = code;
        err      = 1'b0;
        if (syn != 3'd0) begin
            fixed[flip_idx] = ~code[flip_idx];
            err             = 1'b1;
        end
        data = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver with one-entry output register.
// Define HAMMING_ERR_CNT_EN to build the saturating corrected-error counter.
module hamming_serial_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             start,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [3:0]       data_out,
    output logic             data_valid,
    output logic             err_corr,
    output logic             overrun,
    output logic [CNT_W-1:0] err_cnt
);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_nxt;
    logic              wr_en;
    logic [POS_W-1:0]  wr_idx;
    logic              complete;
    logic [CW_LEN-2:0] partial;
    logic [CW_LEN-1:0] full_code;
    logic [3:0]        corr_data;
    logic              corr_err;
    logic              load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            pos   <= '0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
        end
    end

    // pos is the zero-based index of the next expected position; a start always restarts at position 1.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        wr_en     = 1'b0;
        wr_idx    = pos;
        complete  = 1'b0;
        case (state)
            HUNT: begin
                if (bit_valid && start) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    pos_nxt   = POS_W'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (start) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        pos_nxt = POS_W'(1);
                    end else if (pos == POS_W'(CW_LEN - 1)) begin
                        complete = 1'b1;
                        pos_nxt  = '0;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = pos;
                        pos_nxt = pos + POS_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                pos_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial <= '0;
        end else if (wr_en) begin
            partial[wr_idx] <= bit_in;
        end
    end

    // Position 7 is decoded straight off the wire so the nibble registers on its accept edge.
    assign full_code = {bit_in, partial};

    hamming_syndrome_correct u_correct (
        .code (full_code),
        .data (corr_data),
        .err  (corr_err)
    );

    assign load = complete && (!data_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            err_corr   <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                data_out   <= corr_data;
                err_corr   <= corr_err;
                data_valid <= 1'b1;
            end else if (out_ready) begin
                data_valid <= 1'b0;
            end
            if (complete && !load) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (load && corr_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Self-checking bench for hamming_serial_rx: vector table, framing corner cases, randomized frames.
module tb_hamming_serial_rx;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic             clk;
    logic             rst_n;
    logic             bit_in;
    logic             bit_valid;
    logic             start;
    logic             out_ready;
    logic             cnt_clr;
    logic [3:0]       data_out;
    logic             data_valid;
    logic             err_corr;
    logic             overrun;
    logic [CNT_W-1:0] err_cnt;

    int compared;
    int mismatched;
    int model_cnt;
    logic mon_en;
    logic [4:0] exp_q[$];

    logic       dv_log [24];
    logic [3:0] do_log [24];
    logic       ov_log [24];

    typedef struct {
        logic [6:0] code;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    hamming_serial_rx #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .start      (start),
        .out_ready  (out_ready),
        .cnt_clr    (cnt_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err_corr   (err_corr),
        .overrun    (overrun),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int expCnt();
`ifdef HAMMING_ERR_CNT_EN
        return model_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic void countErr(input logic e);
        if (e && model_cnt < CNT_MAX) model_cnt++;
    endfunction

    // Data lands on positions 3,5,6,7; parity bits make the XOR of set-bit positions zero.
    function automatic logic [6:0] encode(input logic [3:0] d);
        int dpos [4];
        int x;
        logic [7:0] w;
        dpos = '{3, 5, 6, 7};
        x = 0;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) begin
                w[dpos[i]] = 1'b1;
                x = x ^ dpos[i];
            end
        end
        if (x[0]) w[1] = 1'b1;
        if (x[1]) w[2] = 1'b1;
        if (x[2]) w[4] = 1'b1;
        return w[7:1];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic b, input logic v, input logic st);
        @(negedge clk);
        bit_in    = b;
        bit_valid = v;
        start     = st;
    endtask

    task automatic applyStimulus(input logic [6:0] code, input logic with_start);
        for (int i = 0; i < 7; i++) begin
            tick(code[i], 1'b1, with_start && (i == 0));
        end
    endtask

    // Sample then drive each cycle: a_len bits of A, then all of B; mode picks out_ready (0 ready, 1 ready at B's last bit, 2 stalled).
    task automatic streamRun(input logic [6:0] a, input int a_len, input logic [6:0] b,
                             input logic b_start, input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            dv_log[k] = data_valid;
            do_log[k] = data_out;
            ov_log[k] = overrun;
            if (k < a_len) begin
                bit_in = a[k]; bit_valid = 1'b1; start = (k == 0);
            end else if (k < a_len + 7) begin
                bit_in = b[k - a_len]; bit_valid = 1'b1; start = b_start && (k == a_len);
            end else begin
                bit_in = 1'b0; bit_valid = 1'b0; start = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k >= a_len + 6);
                default: out_ready = 1'b0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (mon_en && data_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rand_unexpected: got data %0h, expected no output", data_out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rand_data", 32'(data_out), 32'(e[4:1]));
                checkOutput("rand_err", 32'(err_corr), 32'(e[0]));
            end
        end
    end

    initial begin
        int cnt;
        int e_pos;
        logic [3:0] d;
        logic [6:0] code;
        logic force_start;

        compared = 0; mismatched = 0; model_cnt = 0; mon_en = 1'b0;
        bit_in = 1'b0; bit_valid = 1'b0; start = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;

        vecs[0] = '{7'b1010101, 4'b1011, 1'b0};
        vecs[1] = '{7'b1000101, 4'b1011, 1'b1};
        vecs[2] = '{7'b0000000, 4'b0000, 1'b0};
        vecs[3] = '{7'b1111111, 4'b1111, 1'b0};
        vecs[4] = '{7'b0000001, 4'b0000, 1'b1};
        vecs[5] = '{7'b1000000, 4'b0000, 1'b1};
        vecs[6] = '{7'b0000011, 4'b0001, 1'b1};
        vecs[7] = '{7'b1111101, 4'b1111, 1'b1};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", 32'(data_valid), 0);
        checkOutput("reset_data", 32'(data_out), 0);
        checkOutput("reset_err", 32'(err_corr), 0);
        checkOutput("reset_overrun", 32'(overrun), 0);
        checkOutput("reset_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].code, 1'b1);
            tick(1'b0, 1'b0, 1'b0);
            countErr(vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_valid", i), 32'(data_valid), 1);
            checkOutput($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_err", i), 32'(err_corr), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_cnt", i), 32'(err_cnt), 32'(expCnt()));
        end

        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        model_cnt = 0;
        checkOutput("cnt_clr", 32'(err_cnt), 32'(expCnt()));

        // cnt_clr on the same edge as a corrected load must win.
        for (int i = 0; i < 6; i++) tick(vecs[1].code[i], 1'b1, i == 0);
        tick(vecs[1].code[6], 1'b1, 1'b0);
        cnt_clr = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        checkOutput("clr_prio_err", 32'(err_corr), 1);
        checkOutput("clr_prio_cnt", 32'(err_cnt), 32'(expCnt()));

        applyStimulus(7'b0000001, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        countErr(1'b1);
        checkOutput("cnt_after_clr", 32'(err_cnt), 32'(expCnt()));

        streamRun(7'b0000111, 7, 7'b1111111, 1'b0, 0, 18);
        cnt = 0;
        for (int k = 0; k < 18; k++) if (dv_log[k]) cnt++;
        checkOutput("b2b_count", 32'(cnt), 2);
        checkOutput("b2b_first", {27'd0, dv_log[7], do_log[7]}, 32'h11);
        checkOutput("b2b_second", {27'd0, dv_log[14], do_log[14]}, 32'h1F);

        streamRun(7'b0000111, 7, 7'b1111111, 1'b0, 1, 18);
        cnt = 0;
        for (int k = 7; k < 14; k++) if (dv_log[k] && do_log[k] == 4'b0001) cnt++;
        checkOutput("stall_hold", 32'(cnt), 7);
        checkOutput("ready_reload", {27'd0, dv_log[14], do_log[14]}, 32'h1F);
        checkOutput("ready_no_ovr", 32'(ov_log[14]), 0);

        streamRun(7'b0000111, 7, 7'b1111111, 1'b0, 2, 18);
        cnt = 0;
        for (int k = 0; k < 18; k++) if (dv_log[k] && do_log[k] != 4'b0001) cnt++;
        checkOutput("ovr_before", 32'(ov_log[13]), 0);
        checkOutput("ovr_hold", {27'd0, dv_log[14], do_log[14]}, 32'h11);
        checkOutput("ovr_flag", 32'(ov_log[14]), 1);
        checkOutput("ovr_second_seen", 32'(cnt), 0);
        checkOutput("ovr_sticky", 32'(ov_log[17]), 1);

        // Asynchronous reset with a held nibble, a sticky overrun and a partial frame in flight.
        for (int i = 0; i < 3; i++) tick(vecs[6].code[i], 1'b1, i == 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        checkOutput("async_valid", 32'(data_valid), 0);
        checkOutput("async_overrun", 32'(overrun), 0);
        checkOutput("async_data", 32'(data_out), 0);
        checkOutput("async_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 3; i < 7; i++) begin
            tick(vecs[6].code[i], 1'b1, 1'b0);
            if (data_valid) cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (data_valid) cnt++;
        end
        checkOutput("hunt_after_reset", 32'(cnt), 0);

        streamRun(7'b1111111, 3, 7'b1010101, 1'b1, 0, 14);
        cnt = 0;
        for (int k = 0; k < 14; k++) if (dv_log[k]) cnt++;
        checkOutput("restart_count", 32'(cnt), 1);
        checkOutput("restart_data", {27'd0, dv_log[10], do_log[10]}, 32'h1B);

        mon_en = 1'b1;
        force_start = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                cnt = $urandom_range(1, 6);
                for (int i = 0; i < cnt; i++) tick(1'($urandom_range(0, 1)), 1'b1, i == 0);
                force_start = 1'b1;
            end
            d = 4'($urandom_range(0, 15));
            e_pos = $urandom_range(0, 7);
            code = encode(d);
            if (e_pos != 0) code[e_pos - 1] = ~code[e_pos - 1];
            for (int i = 0; i < 7; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
                end
                tick(code[i], 1'b1, (i == 0) && (force_start || ($urandom_range(0, 1) == 1)));
            end
            force_start = 1'b0;
            exp_q.push_back({d, e_pos != 0});
            countErr(e_pos != 0);
        end
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        checkOutput("rand_drained", 32'(exp_q.size()), 0);
        checkOutput("rand_cnt", 32'(err_cnt), 32'(expCnt()));
        checkOutput("rand_no_ovr", 32'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hamming_serial_rx.md
HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

Interface
REQ-001 Parameter CNT_W, default 8, width of the corrected-error counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 bit_in  input  1  serial channel bit.
REQ-005 bit_valid  input  1  bit_in qualifier; one bit is accepted per cycle in which bit_valid=1.
REQ-006 start  input  1  frame sync; qualified by bit_valid, marks the accepted bit as codeword position 1.
REQ-007 out_ready  input  1  downstream ready for the output nibble.
REQ-008 cnt_clr  input  1  synchronous clear of err_cnt.
REQ-009 data_out  output  4  decoded nibble {d4,d3,d2,d1}.
REQ-010 data_valid  output  1  data_out valid; transfer occurs when data_valid=1 and out_ready=1.
REQ-011 err_corr  output  1  single-bit error corrected in the held nibble; valid with data_valid.
REQ-012 overrun  output  1  sticky flag: a completed codeword was dropped.
REQ-013 err_cnt  output  CNT_W  saturating count of corrected codewords.

Function
REQ-014 Codeword positions 1..7 = p1,p2,d1,p4,d2,d3,d4; serial order is position 1 first; internal code[i] holds position i+1.
REQ-015 FSM states HUNT and SHIFT with a 3-bit position counter; HUNT ignores bits until start=1 and bit_valid=1, then stores position 1 and enters SHIFT.
REQ-016 In SHIFT each accepted bit fills the next position; after position 7 is accepted the counter wraps to position 1 and framing continues without a new start.
REQ-017 start=1 with bit_valid=1 in SHIFT discards any partial codeword and takes the bit as position 1; start without bit_valid is ignored.
REQ-018 Syndrome s = {s4,s2,s1}: s1=XOR of positions 1,3,5,7; s2=XOR of 2,3,6,7; s4=XOR of 4,5,6,7.
REQ-019 s!=0 inverts position s before data extraction and sets err_corr; s=0 passes data unchanged with err_corr=0.
REQ-020 Latency: data_valid asserts the cycle after position 7 is accepted; data_out and err_corr are registered.
REQ-021 One-entry output register; data_out, err_corr and data_valid stay stable while data_valid=1 and out_ready=0.
REQ-022 Completion while the register is empty, or while full with out_ready=1 in that cycle, loads the new nibble (back-to-back without a bubble).
REQ-023 Completion while the register is full and out_ready=0 drops the new codeword, keeps the held nibble and sets overrun until reset.
REQ-024 err_cnt increments by 1 per loaded codeword with err_corr=1, saturates at 2^CNT_W-1, and is cleared by cnt_clr; cnt_clr has priority over a simultaneous increment.

Reset
REQ-025 rst_n=0 immediately forces FSM=HUNT, counter=0, data_valid=0, data_out=0, err_corr=0, overrun=0, err_cnt=0.
REQ-026 Reset mid-codeword discards the partial codeword; after release the block waits in HUNT for start.

Configuration
REQ-027 Macro HAMMING_ERR_CNT_EN defined: err_cnt and cnt_clr behave per REQ-024.
REQ-028 Macro HAMMING_ERR_CNT_EN undefined: no counter register exists, err_cnt is tied to 0, and cnt_clr is unused.

Structure
REQ-029 Shared package hamming_pkg holds the FSM state typedef, the position-width constant (3), and the codeword length constant (7).
REQ-030 Sub-module hamming_syndrome_correct is purely combinational: 7-bit code in, corrected 4-bit data and err flag out.

Verification
REQ-031 Reset, start on bits 1,0,1,0,1,0,1 (code 7'b1010101) -> data_valid 1 cycle after bit 7, data_out=4'b1011, err_corr=0.
REQ-032 Same codeword with position 5 inverted (7'b1000101) -> data_out=4'b1011, err_corr=1, err_cnt=1.
REQ-033 Two continuous codewords with no second start and out_ready=1 -> two nibbles with no bubble between them.
REQ-034 out_ready=0 while a second codeword completes -> first nibble held stable, overrun=1, second nibble never output.
REQ-035 start asserted at position 4 of a frame -> partial frame discarded, next output decoded from the new frame.
REQ-036 CNT_W=2 with 5 corrected codewords -> err_cnt saturates at 3; cnt_clr -> 0; build without HAMMING_ERR_CNT_EN -> err_cnt stays 0.
